ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Instruction fetch initiator that drives the instruction memory's combinational read port (PC address in; instruction and exception fields out).
- Generates the sequential fetch PC and captures each returned word with its PC and exception status into a small in-order fetch queue.
- Presents the queue head to decode over a valid/ready handshake.
- Handles redirects (branch/trap) and halts fetching after a fetch fault until redirected.

Parameters:
- RESET_PC, 64'h0, fetch PC loaded at reset.
- QDEPTH, 2, fetch queue entries; power of two, ≥2.
- NOP_INSTR, 32'h00000013, instruction field presented for faulted or empty entries.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- imem_addr  out  64  fetch address to instruction memory; equals fetch_pc register.
- imem_instr  in  32  instruction read at imem_addr, same cycle.
- imem_exc_en  in  1  instruction access fault for imem_addr, same cycle.
- imem_exc_code  in  4  fault cause from memory.
- imem_exc_val  in  64  faulting address from memory.
- redirect_en  in  1  flush and restart fetch.
- redirect_pc  in  64  new fetch PC.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts head.
- out_pc  out  64  PC of head entry.
- out_instr  out  32  instruction of head entry.
- out_exc_en  out  1  head entry carries a fetch exception.
- out_exc_code  out  4  exception cause.
- out_exc_val  out  64  exception value (mtval).
- fetch_halted  out  1  fetch stopped after a fault.

Behaviour:
- Reset (rst=0 at edge):
  - fetch_pc=RESET_PC, queue count=0, state=RUN.
  - out_valid=0, out_pc=0, out_instr=NOP_INSTR, out_exc_en=0, out_exc_code=0, out_exc_val=0, fetch_halted=0.
  - Reset overrides redirect and any handshake in the same cycle.
- imem_addr=fetch_pc combinationally; no other logic in that path.
- States: RUN, HALT.
- pop = out_valid & out_ready. push = (state==RUN) & (count<QDEPTH | pop) & !redirect_en.
- On push, the entry is {fetch_pc, instr, exc_en, code, val}, selected by priority:
  1. fetch_pc[1:0]!=0: misaligned. instr=NOP_INSTR, exc_en=1, code=0, val=fetch_pc. Memory exception inputs are ignored.
  2. imem_exc_en=1: instr=NOP_INSTR, exc_en=1, code=imem_exc_code, val=imem_exc_val.
  3. Otherwise: instr=imem_instr, exc fields zero.
- After a push:
  - Exception entry: state→HALT; fetch_pc is held at the faulting PC.
  - Normal entry: fetch_pc←fetch_pc+4, modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC wraps to 0).
- HALT:
  - No pushes; the queue drains normally via pop; fetch_halted=1.
  - Exits only via redirect or reset.
- Redirect (redirect_en=1), highest priority after reset:
  - Queue count←0, including the head even if out_ready=1 that cycle. The issuer of the redirect owns the kill.
  - fetch_pc←redirect_pc; state→RUN; no push that cycle.
  - First redirected entry is visible at out one cycle later (out_valid low for exactly one cycle).
- Latency and throughput:
  - A word fetched in cycle N appears at out in cycle N+1.
  - Sustained throughput is 1 instruction/cycle while out_ready=1.
- Queue:
  - Circular buffer with registered outputs; out_* reflect the head entry and depend only on registered state (no ready→valid or redirect→valid combinational path).
  - When empty, out_* show reset values.
  - Push+pop in the same cycle leaves count unchanged.
  - Full without pop: no fetch, fetch_pc held, imem_addr stable.
- Ordering: entries leave in fetch order; no entry is lost or duplicated across backpressure.
- Memory fault behaviour: the memory may drop imem_exc_en on the following cycle. Only the push-cycle sample matters, because the block halts immediately.

Test Plan:
- Reset release, RESET_PC=0, out_ready=1, imem returns 0x1000_0000|pc → out_valid rises 1 cycle after release; out_pc=0,4,8,12 on consecutive cycles; out_instr matches each PC.
- out_ready=0 for 5 cycles from start → exactly 2 entries held (pc 0,4); imem_addr stuck at 8. Then ready=1 → out_pc 0,4,8,12 with no gap after the head and no duplicates.
- Redirect to 0x100 while queue holds 2 entries and ready=1 → next cycle out_valid=0; following cycle out_pc=0x100; then 0x104.
- imem_exc_en=1, code=1, val=0x40000 at fetch_pc=0x40000 → entry out_exc_en=1, code=1, val=0x40000, instr=0x13; fetch_halted=1; no later entries. Redirect to 0 → fetch_halted=0, out_pc=0 next-plus-one cycle.
- Redirect to 0x102 with imem_exc_en=1 → entry code=0 (misaligned wins), val=0x102; halted.
- Full queue, redirect_en=1 and rst=0 in the same cycle → next cycle out_valid=0, imem_addr=RESET_PC, fetch_halted=0.

Source files
------------

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - sequential instruction fetch with in-order fetch queue, redirect and fault halt
module ifetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          QDEPTH    = 2,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        imem_exc_en,
  input  logic [3:0]  imem_exc_code,
  input  logic [63:0] imem_exc_val,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_exc_en,
  output logic [3:0]  out_exc_code,
  output logic [63:0] out_exc_val,
  output logic        fetch_halted
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(QDEPTH);

  typedef enum logic [0:0] {RUN, HALT} state_t;

  state_t state, next_state;

  logic [63:0]   fetch_pc;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  logic [63:0] q_pc       [QDEPTH];
  logic [31:0] q_instr    [QDEPTH];
  logic        q_exc_en   [QDEPTH];
  logic [3:0]  q_exc_code [QDEPTH];
  logic [63:0] q_exc_val  [QDEPTH];

  logic        pop, push;
  logic [31:0] new_instr;
  logic        new_exc_en;
  logic [3:0]  new_exc_code;
  logic [63:0] new_exc_val;

  assign imem_addr = fetch_pc;

  // Head of queue is presented straight from registers; empty queue shows idle values
  assign out_valid    = (count != '0);
  assign out_pc       = out_valid ? q_pc[head]       : 64'h0;
  assign out_instr    = out_valid ? q_instr[head]    : NOP_INSTR;
  assign out_exc_en   = out_valid ? q_exc_en[head]   : 1'b0;
  assign out_exc_code = out_valid ? q_exc_code[head] : 4'h0;
  assign out_exc_val  = out_valid ? q_exc_val[head]  : 64'h0;
  assign fetch_halted = (state == HALT);

  assign pop  = out_valid & out_ready;
  assign push = (state == RUN) & ((count < DEPTH) | pop) & ~redirect_en;

  // Build the entry for the current fetch; misalignment outranks a memory fault
  always_comb begin
    new_instr    = imem_instr;
    new_exc_en   = 1'b0;
    new_exc_code = 4'h0;
    new_exc_val  = 64'h0;
    if (fetch_pc[1:0] != 2'b00) begin
      new_instr    = NOP_INSTR;
      new_exc_en   = 1'b1;
      new_exc_val  = fetch_pc;
    end else if (imem_exc_en) begin
      new_instr    = NOP_INSTR;
      new_exc_en   = 1'b1;
      new_exc_code = imem_exc_code;
      new_exc_val  = imem_exc_val;
    end
  end

  // Next fetch state: redirect always resumes, a faulted push stops fetching
  always_comb begin
    next_state = state;
    if (redirect_en) begin
      next_state = RUN;
    end else if (push && new_exc_en) begin
      next_state = HALT;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Fetch PC, queue pointers and occupancy; redirect kills every entry including the head
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect_en) begin
      fetch_pc <= redirect_pc;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        tail <= tail + PW'(1);
        if (!new_exc_en) begin
          fetch_pc <= fetch_pc + 64'd4;
        end
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Queue storage; contents are only meaningful behind the occupancy count
  always_ff @(posedge clk) begin
    if (rst && push) begin
      q_pc[tail]       <= fetch_pc;
      q_instr[tail]    <= new_instr;
      q_exc_en[tail]   <= new_exc_en;
      q_exc_code[tail] <= new_exc_code;
      q_exc_val[tail]  <= new_exc_val;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed self-checking bench for ifetch_unit
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        imem_exc_en;
  logic [3:0]  imem_exc_code;
  logic [63:0] imem_exc_val;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_exc_en;
  logic [3:0]  out_exc_code;
  logic [63:0] out_exc_val;
  logic        fetch_halted;

  logic        exc_arm;
  logic [63:0] exc_addr;

  int checks_total = 0;
  int checks_passed = 0;

  ifetch_unit #(
    .RESET_PC(64'h0),
    .QDEPTH(2),
    .NOP_INSTR(32'h00000013)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_addr(imem_addr),
    .imem_instr(imem_instr),
    .imem_exc_en(imem_exc_en),
    .imem_exc_code(imem_exc_code),
    .imem_exc_val(imem_exc_val),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_instr(out_instr),
    .out_exc_en(out_exc_en),
    .out_exc_code(out_exc_code),
    .out_exc_val(out_exc_val),
    .fetch_halted(fetch_halted)
  );

  always #5 clk = ~clk;

  // Memory model: word = 0x1000_0000 | addr, optional fault at one address
  always_comb begin
    imem_instr  = 32'h1000_0000 | imem_addr[31:0];
    imem_exc_en = exc_arm && (imem_addr == exc_addr);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    rst = 1'b0;
    out_ready = ready;
    redirect_en = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    out_ready = 1'b1;
    redirect_en = 1'b0;
    redirect_pc = 64'h0;
    exc_arm = 1'b0;
    exc_addr = 64'h0;
    imem_exc_code = 4'h0;
    imem_exc_val = 64'h0;

    // Reset state
    do_reset(1'b1);
    check("rst_valid", {63'h0, out_valid}, 64'h0);
    check("rst_pc", out_pc, 64'h0);
    check("rst_instr", {32'h0, out_instr}, 64'h13);
    check("rst_exc_en", {63'h0, out_exc_en}, 64'h0);
    check("rst_exc_code", {60'h0, out_exc_code}, 64'h0);
    check("rst_exc_val", out_exc_val, 64'h0);
    check("rst_halted", {63'h0, fetch_halted}, 64'h0);
    check("rst_addr", imem_addr, 64'h0);

    // Streaming at one per cycle
    for (int i = 0; i < 4; i++) begin
      step();
      check("stream_valid", {63'h0, out_valid}, 64'h1);
      check("stream_pc", out_pc, 64'(4 * i));
      check("stream_instr", {32'h0, out_instr}, 64'h1000_0000 | 64'(4 * i));
    end

    // Backpressure: two entries held, fetch stalls at 8
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) step();
    check("bp_valid", {63'h0, out_valid}, 64'h1);
    check("bp_head", out_pc, 64'h0);
    check("bp_addr", imem_addr, 64'h8);
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      check("bp_drain_valid", {63'h0, out_valid}, 64'h1);
      check("bp_drain_pc", out_pc, 64'(4 * i));
    end

    // Redirect with a full queue and ready high
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) step();
    check("rd_pre_addr", imem_addr, 64'h8);
    out_ready = 1'b1;
    redirect_en = 1'b1;
    redirect_pc = 64'h100;
    step();
    redirect_en = 1'b0;
    check("rd_bubble", {63'h0, out_valid}, 64'h0);
    check("rd_addr", imem_addr, 64'h100);
    step();
    check("rd_first_valid", {63'h0, out_valid}, 64'h1);
    check("rd_first_pc", out_pc, 64'h100);
    step();
    check("rd_second_pc", out_pc, 64'h104);

    // Memory access fault halts fetch
    exc_arm = 1'b1;
    exc_addr = 64'h40000;
    imem_exc_code = 4'h1;
    imem_exc_val = 64'h40000;
    redirect_en = 1'b1;
    redirect_pc = 64'h40000;
    step();
    redirect_en = 1'b0;
    check("flt_bubble", {63'h0, out_valid}, 64'h0);
    step();
    exc_arm = 1'b0;
    check("flt_valid", {63'h0, out_valid}, 64'h1);
    check("flt_pc", out_pc, 64'h40000);
    check("flt_exc_en", {63'h0, out_exc_en}, 64'h1);
    check("flt_code", {60'h0, out_exc_code}, 64'h1);
    check("flt_val", out_exc_val, 64'h40000);
    check("flt_instr", {32'h0, out_instr}, 64'h13);
    check("flt_halted", {63'h0, fetch_halted}, 64'h1);
    check("flt_addr_hold", imem_addr, 64'h40000);
    step();
    check("flt_no_more", {63'h0, out_valid}, 64'h0);
    step();
    check("flt_still_empty", {63'h0, out_valid}, 64'h0);
    check("flt_still_halted", {63'h0, fetch_halted}, 64'h1);
    redirect_en = 1'b1;
    redirect_pc = 64'h0;
    step();
    redirect_en = 1'b0;
    check("flt_resume_halted", {63'h0, fetch_halted}, 64'h0);
    check("flt_resume_bubble", {63'h0, out_valid}, 64'h0);
    step();
    check("flt_resume_valid", {63'h0, out_valid}, 64'h1);
    check("flt_resume_pc", out_pc, 64'h0);

    // Misalignment outranks a simultaneous memory fault
    exc_arm = 1'b1;
    exc_addr = 64'h102;
    imem_exc_code = 4'h5;
    imem_exc_val = 64'hdead;
    redirect_en = 1'b1;
    redirect_pc = 64'h102;
    step();
    redirect_en = 1'b0;
    step();
    exc_arm = 1'b0;
    check("mis_exc_en", {63'h0, out_exc_en}, 64'h1);
    check("mis_code", {60'h0, out_exc_code}, 64'h0);
    check("mis_val", out_exc_val, 64'h102);
    check("mis_pc", out_pc, 64'h102);
    check("mis_halted", {63'h0, fetch_halted}, 64'h1);

    // PC wraps past the top of the address space
    redirect_en = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect_en = 1'b0;
    step();
    check("wrap_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_addr", imem_addr, 64'h0);
    step();
    check("wrap_next_pc", out_pc, 64'h0);

    // Reset beats redirect with a full queue
    out_ready = 1'b0;
    redirect_en = 1'b1;
    redirect_pc = 64'h0;
    step();
    redirect_en = 1'b0;
    step();
    step();
    check("rr_full_valid", {63'h0, out_valid}, 64'h1);
    rst = 1'b0;
    redirect_en = 1'b1;
    redirect_pc = 64'h500;
    out_ready = 1'b1;
    step();
    check("rr_valid", {63'h0, out_valid}, 64'h0);
    check("rr_addr", imem_addr, 64'h0);
    check("rr_halted", {63'h0, fetch_halted}, 64'h0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
